shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 17 +
 rtl/barrel_shifter.sv | 32 +++
 rtl/shift_arbiter.sv | 119 +++++++++++
 tb/tb_shift_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the shift arbiter: operation codes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logarithmic barrel shifter.
//   in    : operand
//   shamt : shift amount, SHW bits (always < WIDTH)
//   dir   : 0 = shift left (zero fill), 1 = shift right
//   fill  : bit shifted in from the top on right shifts
//   out   : shifted operand
module barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] out
);

    // stg[i] is the operand after the first i binary-weighted stages.
    logic [WIDTH-1:0] stg [SHW+1];

    assign stg[0] = in;

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        localparam int S = 1 << i;
        assign stg[i+1] = !shamt[i] ? stg[i] :
                          dir       ? {{S{fill}}, stg[i][WIDTH-1:S]} :
                                      {stg[i][WIDTH-1-S:0], {S{1'b0}}};
    end

    assign out = stg[SHW];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared shifter.
// One operation in flight at a time: IDLE (accept) -> EXEC (shift) ->
// DONE (hold result until consumed).
//   clk, rst_n              : clock, async active-low reset
//   reqN_valid/ready        : request handshake per requester
//   reqN_data/shamt/op      : operand, 32-bit unsigned amount, operation
//   res_valid/ready         : result handshake
//   res_data, res_id        : result and owning requester
//   busy                    : FSM not in IDLE
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [31:0]      req0_shamt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [31:0]      req1_shamt,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] cap_data;
    logic [31:0]      cap_shamt;
    shift_op_e        cap_op;
    logic             cap_id;
    logic             last_id;

    logic             any_req, grant_id, hs;
    logic [WIDTH-1:0] shifted, result;
    logic             over, msb, dir, fill;

    // Contended grant goes to whoever was not served last; otherwise to
    // the only requester asserting valid.
    assign any_req    = req0_valid | req1_valid;
    assign grant_id   = (req0_valid & req1_valid) ? ~last_id : req1_valid;
    assign req0_ready = (state == IDLE) & any_req & ~grant_id;
    assign req1_ready = (state == IDLE) & grant_id;
    assign hs         = (state == IDLE) & any_req;
    assign busy       = (state != IDLE);

    // Amounts beyond the operand width saturate; the shifter itself only
    // sees the low SHW bits.
    assign over = (cap_shamt > 32'(WIDTH-1));
    assign msb  = cap_data[WIDTH-1];
    assign dir  = (cap_op != OP_SLL);
    assign fill = (cap_op == OP_SRA) & msb;

    barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .in    (cap_data),
        .shamt (cap_shamt[SHW-1:0]),
        .dir   (dir),
        .fill  (fill),
        .out   (shifted)
    );

    always_comb begin
        result = shifted;
        if (cap_op == OP_PASS)
            result = cap_data;
        else if (over)
            result = (cap_op == OP_SRA) ? {WIDTH{msb}} : '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_data  <= '0;
            cap_shamt <= '0;
            cap_op    <= OP_SLL;
            cap_id    <= 1'b0;
            last_id   <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                cap_data  <= grant_id ? req1_data  : req0_data;
                cap_shamt <= grant_id ? req1_shamt : req0_shamt;
                cap_op    <= shift_op_e'(grant_id ? req1_op : req0_op);
                cap_id    <= grant_id;
                last_id   <= grant_id;
            end
            // Result registered at the end of EXEC and held through DONE.
            if (state == EXEC) begin
                res_data  <= result;
                res_id    <= cap_id;
                res_valid <= 1'b1;
            end else if (state == DONE && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    localparam int W = 32;
    localparam int SHW = 5;

    logic          clk, rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_data, req1_data;
    logic [31:0]   req0_shamt, req1_shamt;
    logic [1:0]    req0_op, req1_op;
    logic          res_valid, res_ready, res_id, busy;
    logic [W-1:0]  res_data;

    shift_arbiter #(.WIDTH(W), .SHW(SHW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] data; logic id; } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_tb  = 1'b1;

    function automatic logic [W-1:0] model(logic [W-1:0] d, logic [31:0] s, logic [1:0] op);
        logic [4:0] sa;
        sa = (s > 31) ? 5'd31 : s[4:0];
        case (op)
            2'b00:   return (s > 31) ? '0 : (d << sa);
            2'b01:   return (s > 31) ? '0 : (d >> sa);
            2'b10:   return $unsigned($signed(d) >>> sa);
            default: return d;
        endcase
    endfunction

    task automatic drive_req(input logic id, input logic [W-1:0] d, input logic [31:0] s,
                             input logic [1:0] op);
        exp_t e;
        if (!id) begin req0_valid = 1; req0_data = d; req0_shamt = s; req0_op = op; end
        else     begin req1_valid = 1; req1_data = d; req1_shamt = s; req1_op = op; end
        e.data = model(d, s, op);
        e.id   = id;
        sb.push_back(e);
        last_tb = id;
    endtask

    // Drop valids and scramble operands so late input changes are visible.
    task automatic clear_req();
        req0_valid = 0; req1_valid = 0;
        req0_data = 32'hA5A5_5A5A; req1_data = 32'h5A5A_A5A5;
        req0_shamt = 32'd3; req1_shamt = 32'd9;
        req0_op = 2'b01; req1_op = 2'b00;
    endtask

    // Called at a negedge; returns with ok=1 at the negedge where res_valid is seen.
    task automatic wait_res(output bit ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) begin ok = 1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 0; res_ready = 1; clear_req();
        repeat (2) @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        n_checks++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL reset_res_id: got %b want 0", res_id); end
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        rst_n = 1; last_tb = 1;
        @(negedge clk);
    endtask

    task automatic test_sll_latency();
        exp_t e;
        drive_req(0, 32'h0000_0001, 32'd4, 2'b00);
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL sll_grant: got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);               // handshake edge has passed
        clear_req();
        n_checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL sll_exec: res_valid %b busy %b want 0 1", res_valid, busy); end
        @(negedge clk);               // one edge later: result registered
        e = sb.pop_front();
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL sll_latency: res_valid %b want 1", res_valid); end
        n_checks++; if (res_data !== e.data || res_id !== e.id) begin n_fail++; $display("FAIL sll_result: got %h/%b want %h/%b", res_data, res_id, e.data, e.id); end
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sll_drain: res_valid %b busy %b want 0 0", res_valid, busy); end
    endtask

    typedef struct { logic id; logic [31:0] d; logic [31:0] s; logic [1:0] op; } vec_t;

    task automatic test_shift_ops();
        vec_t tbl[7];
        exp_t e;
        bit   ok;
        tbl = '{'{1'b1, 32'h8000_0000, 32'd40, 2'b10},
                '{1'b1, 32'h8000_0000, 32'd40, 2'b01},
                '{1'b0, 32'hDEAD_BEEF, 32'd7,  2'b11},
                '{1'b0, 32'h0000_0001, 32'd32, 2'b00},
                '{1'b1, 32'h8000_0000, 32'd31, 2'b01},
                '{1'b0, 32'h8000_00F0, 32'd4,  2'b10},
                '{1'b1, 32'h1234_5678, 32'd0,  2'b01}};
        foreach (tbl[k]) begin
            drive_req(tbl[k].id, tbl[k].d, tbl[k].s, tbl[k].op);
            @(negedge clk);
            clear_req();
            wait_res(ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL op%0d_timeout: no res_valid", k); end
            else if (res_data !== e.data || res_id !== e.id) begin
                n_fail++; $display("FAIL op%0d_result: got %h/%b want %h/%b", k, res_data, res_id, e.data, e.id);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        res_ready = 0;
        drive_req(0, 32'h0F0F_0F0F, 32'd8, 2'b01);
        @(negedge clk);
        clear_req();
        req1_valid = 1;               // a competing request must stay blocked
        wait_res(ok);
        e = sb.pop_front();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_timeout: no res_valid"); end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== e.data || res_id !== e.id || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_c%0d: v %b data %h id %b rdy %b%b want 1 %h %b 00",
                         c, res_valid, res_data, res_id, req0_ready, req1_ready, e.data, e.id);
            end
            @(negedge clk);
        end
        res_ready = 1;
        @(negedge clk);               // DONE-exit edge passed with req1 still valid
        n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL hold_exit: busy %b res_valid %b want 0 0", busy, res_valid); end
        clear_req();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        logic exp_order [4];
        logic g;
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 0; @(negedge clk); rst_n = 1; last_tb = 1;
        req0_valid = 1; req0_data = 32'h0000_00F1; req0_shamt = 32'd1; req0_op = 2'b00;
        req1_valid = 1; req1_data = 32'hF000_0000; req1_shamt = 32'd2; req1_op = 2'b10;
        for (int k = 0; k < 4; k++) begin
            g = ~last_tb;
            e.id   = g;
            e.data = g ? model(req1_data, req1_shamt, req1_op) : model(req0_data, req0_shamt, req0_op);
            sb.push_back(e);
            last_tb = g;
        end
        for (int k = 0; k < 4; k++) begin
            wait_res(ok);
            e = sb.pop_front();
            if (k == 3) clear_req();  // stop before the exit edge re-arms
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL b2b%0d_timeout: no res_valid", k); end
            else if (res_id !== e.id || res_id !== exp_order[k] || res_data !== e.data) begin
                n_fail++; $display("FAIL b2b%0d: got id %b data %h want id %b data %h", k, res_id, res_data, exp_order[k], e.data);
            end
            n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL b2b%0d_ready: got %b want 00", k, {req0_ready, req1_ready}); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_exec();
        exp_t e;
        bit   ok;
        drive_req(0, 32'h0000_0003, 32'd1, 2'b00);
        @(negedge clk);               // now in EXEC
        clear_req();
        void'(sb.pop_back());         // this operation is discarded
        rst_n = 0;
        #1;
        n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_exec_async: res_valid %b busy %b want 0 0", res_valid, busy); end
        @(negedge clk);
        rst_n = 1; last_tb = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_exec_idle%0d: res_valid %b busy %b want 0 0", c, res_valid, busy); end
        end
        drive_req(1, 32'h0000_0080, 32'd3, 2'b01);
        drive_req(0, 32'h0000_0080, 32'd3, 2'b00);
        void'(sb.pop_front());        // req1 loses: pointer reset to 1
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_exec_grant: got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        clear_req();
        wait_res(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_exec_timeout: no res_valid"); end
        else if (res_id !== e.id || res_data !== e.data) begin
            n_fail++; $display("FAIL rst_exec_result: got %h/%b want %h/%b", res_data, res_id, e.data, e.id);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; res_ready = 1;
        clear_req();
        @(negedge clk);
        test_reset();
        test_sll_latency();
        test_shift_ops();
        test_hold();
        test_back_to_back();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
